interrupt_controller: RTL and testbench

Upstream sequencer for the register stacking unit. Detects and prioritises external interrupt lines, then issues the single-cycle interrupt and return-from-interrupt pulses that start register stacking and unstacking. Stalls the pipeline while stacking or unstacking is in progress, and gives the fetch stage a one-cycle PC redirect to the handler vector. Sits between the interrupt pins / retire stage and the stacking unit's `interrupt_signal_in` / `return_interrupt_signal_in`.

---
 rtl/interrupt_controller.sv | 152 +++++++++++++++
 tb/tb_interrupt_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Edge-detects and prioritises IRQ lines, then sequences stacking entry/return.
// Latency: pending set on edge k, interrupt_signal_out high after edge k+1; all outputs registered.
// Backpressure: stalls fetch while stacking/unstacking, waits on stacking_busy_in and restore_done_in.
module interrupt_controller #(
    parameter int          IRQ_COUNT    = 8,
    parameter int          IRQ_ID_WIDTH = 3,
    parameter logic [63:0] VECTOR_BASE  = 64'h0000_0000_0000_0100
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic [IRQ_COUNT-1:0]    irq_in,
    input  logic [IRQ_COUNT-1:0]    irq_enable_in,
    input  logic                    global_enable_in,
    input  logic                    mret_in,
    input  logic                    stacking_busy_in,
    input  logic                    restore_done_in,
    output logic                    interrupt_signal_out,
    output logic                    return_interrupt_signal_out,
    output logic                    pipeline_stall_out,
    output logic                    redirect_out,
    output logic [63:0]             vector_address_out,
    output logic [IRQ_ID_WIDTH-1:0] active_irq_out,
    output logic                    in_service_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_STACKING,
        S_SERVICE,
        S_RETURN,
        S_UNSTACKING
    } state_t;

    state_t                  state_q, state_d;
    logic [IRQ_COUNT-1:0]    irq_prev_q;
    logic [IRQ_COUNT-1:0]    pending_q, pending_d;
    logic [IRQ_COUNT-1:0]    eligible, clear_mask;
    logic                    any_eligible;
    logic [IRQ_ID_WIDTH-1:0] winner;
    logic                    seen_busy_q, seen_busy_d;

    logic                    intr_d, ret_d, stall_d, redir_d, insvc_d;
    logic [IRQ_ID_WIDTH-1:0] act_d;
    logic [63:0]             vec_d;

    assign eligible     = pending_q & irq_enable_in & {IRQ_COUNT{global_enable_in}};
    assign any_eligible = |eligible;

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        winner = '0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = IRQ_ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        seen_busy_d = seen_busy_q;
        clear_mask  = '0;
        intr_d      = 1'b0;
        ret_d       = 1'b0;
        redir_d     = 1'b0;
        stall_d     = pipeline_stall_out;
        insvc_d     = in_service_out;
        act_d       = active_irq_out;
        vec_d       = vector_address_out;
        case (state_q)
            S_IDLE: begin
                if (any_eligible) begin
                    state_d    = S_ENTRY;
                    intr_d     = 1'b1;
                    stall_d    = 1'b1;
                    insvc_d    = 1'b1;
                    act_d      = winner;
                    vec_d      = VECTOR_BASE + (64'(winner) << 2);
                    clear_mask = IRQ_COUNT'(1) << winner;
                end
            end
            S_ENTRY: begin
                state_d     = S_STACKING;
                seen_busy_d = 1'b0;
            end
            S_STACKING: begin
                // Only a busy high-then-low sequence counts as stacking finished.
                if (seen_busy_q && !stacking_busy_in) begin
                    state_d = S_SERVICE;
                    redir_d = 1'b1;
                    stall_d = 1'b0;
                end else if (stacking_busy_in) begin
                    seen_busy_d = 1'b1;
                end
            end
            S_SERVICE: begin
                if (mret_in) begin
                    state_d = S_RETURN;
                    ret_d   = 1'b1;
                    stall_d = 1'b1;
                end
            end
            S_RETURN: begin
                state_d = S_UNSTACKING;
            end
            S_UNSTACKING: begin
                if (restore_done_in) begin
                    state_d = S_IDLE;
                    stall_d = 1'b0;
                    insvc_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                stall_d = 1'b0;
                insvc_d = 1'b0;
            end
        endcase
        // A fresh rising edge beats the clear of the bit just accepted.
        pending_d = (pending_q & ~clear_mask) | (irq_in & ~irq_prev_q);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q                     <= S_IDLE;
            irq_prev_q                  <= '1;
            pending_q                   <= '0;
            seen_busy_q                 <= 1'b0;
            interrupt_signal_out        <= 1'b0;
            return_interrupt_signal_out <= 1'b0;
            pipeline_stall_out          <= 1'b0;
            redirect_out                <= 1'b0;
            in_service_out              <= 1'b0;
            active_irq_out              <= '0;
            vector_address_out          <= VECTOR_BASE;
        end else begin
            state_q                     <= state_d;
            irq_prev_q                  <= irq_in;
            pending_q                   <= pending_d;
            seen_busy_q                 <= seen_busy_d;
            interrupt_signal_out        <= intr_d;
            return_interrupt_signal_out <= ret_d;
            pipeline_stall_out          <= stall_d;
            redirect_out                <= redir_d;
            in_service_out              <= insvc_d;
            active_irq_out              <= act_d;
            vector_address_out          <= vec_d;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus a random phase, checked every cycle against a behavioural model.
module tb_interrupt_controller;

    localparam logic [63:0] BASE = 64'h0000_0000_0000_0100;
    localparam int P_IDLE = 0, P_ENTRY = 1, P_STACK = 2, P_SERVICE = 3, P_RETURN = 4, P_UNSTACK = 5;

    logic        clk, rst_n;
    logic [7:0]  irq, en;
    logic        gen, mret, busy, done;
    logic        intr_o, ret_o, stall_o, redir_o, insvc_o;
    logic [63:0] vec_o;
    logic [2:0]  act_o;

    int total = 0;
    int bad   = 0;
    int n_intr, n_ret;

    // Reference model state
    logic [7:0]  m_pend, m_prev;
    int          m_ph;
    bit          m_seen, m_redir;
    int          m_act;

    interrupt_controller #(.IRQ_COUNT(8), .IRQ_ID_WIDTH(3), .VECTOR_BASE(BASE)) dut (
        .clk_in                      (clk),
        .reset_n_in                  (rst_n),
        .irq_in                      (irq),
        .irq_enable_in               (en),
        .global_enable_in            (gen),
        .mret_in                     (mret),
        .stacking_busy_in            (busy),
        .restore_done_in             (done),
        .interrupt_signal_out        (intr_o),
        .return_interrupt_signal_out (ret_o),
        .pipeline_stall_out          (stall_o),
        .redirect_out                (redir_o),
        .vector_address_out          (vec_o),
        .active_irq_out              (act_o),
        .in_service_out              (insvc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_prev  = '1;
        m_ph    = P_IDLE;
        m_seen  = 1'b0;
        m_redir = 1'b0;
        m_act   = 0;
    endtask

    task automatic model_edge();
        logic [7:0] rise, elig, clr;
        rise    = irq & ~m_prev;
        m_prev  = irq;
        clr     = '0;
        m_redir = 1'b0;
        case (m_ph)
            P_IDLE: begin
                elig = gen ? (m_pend & en) : 8'h00;
                if (elig != 0) begin
                    int w = 0;
                    while (!elig[w]) w++;
                    m_act  = w;
                    clr[w] = 1'b1;
                    m_ph   = P_ENTRY;
                end
            end
            P_ENTRY: begin
                m_seen = 1'b0;
                m_ph   = P_STACK;
            end
            P_STACK: begin
                if (m_seen && !busy) begin
                    m_ph    = P_SERVICE;
                    m_redir = 1'b1;
                end else if (busy) m_seen = 1'b1;
            end
            P_SERVICE: if (mret) m_ph = P_RETURN;
            P_RETURN:  m_ph = P_UNSTACK;
            default:   if (done) m_ph = P_IDLE;
        endcase
        m_pend = (m_pend & ~clr) | rise;
    endtask

    task automatic check_all();
        chk("intr",   intr_o,  m_ph == P_ENTRY);
        chk("ret",    ret_o,   m_ph == P_RETURN);
        chk("stall",  stall_o, !(m_ph == P_IDLE || m_ph == P_SERVICE));
        chk("redir",  redir_o, m_redir);
        chk("insvc",  insvc_o, m_ph != P_IDLE);
        chk("act",    act_o,   m_act);
        chk("vector", vec_o,   BASE + 64'(m_act) * 4);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
            n_intr += int'(intr_o);
            n_ret  += int'(ret_o);
        end
    endtask

    task automatic wait_intr(input int lim, output int k);
        k = 0;
        while (!intr_o && k < lim) begin
            tick();
            k++;
        end
        chk("intr_seen", intr_o, 1);
    endtask

    // Called in the ENTRY cycle; plays the stacking unit and the retiring mret.
    task automatic run_isr(input int busy_n, input int rest_n);
        busy = 1'b1;
        tick(busy_n);
        busy = 1'b0;
        tick();
        chk("isr_redirect", redir_o, 1);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("isr_ret_pulse", ret_o, 1);
        tick(rest_n);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("isr_idle", insvc_o, 0);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int k, b;
        rst_n = 1'b0; irq = 8'h01; en = 8'hFF; gen = 1'b1;
        mret = 1'b0; busy = 1'b0; done = 1'b0;
        n_intr = 0; n_ret = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 rst_n = 1'b1;

        // irq[0] held high through release must not fire
        tick(5);
        chk("no_fire_after_reset", n_intr, 0);
        irq = 8'h00;
        tick(2);

        // Single interrupt on line 3
        n_intr = 0; n_ret = 0;
        irq = 8'h08;
        wait_intr(10, k);
        chk("latency", k, 2);
        chk("s1_act", act_o, 3);
        chk("s1_vec", vec_o, 64'h10C);
        run_isr(10, 6);
        tick(3);
        chk("s1_one_intr", n_intr, 1);
        chk("s1_one_ret", n_ret, 1);

        // Priority: 1 before 5, then 5 after exactly one idle cycle
        irq = 8'h00;
        tick();
        irq = 8'h22;
        wait_intr(10, k);
        chk("pri_act", act_o, 1);
        chk("pri_vec", vec_o, 64'h104);
        run_isr(4, 2);
        tick();
        chk("pri_second_entry", intr_o, 1);
        chk("pri_second_act", act_o, 5);
        run_isr(3, 1);

        // Masking: line 2 held off for 20 cycles
        irq = 8'h00; en = 8'hFB;
        tick();
        n_intr = 0;
        irq = 8'h04;
        tick(20);
        chk("mask_no_pulse", n_intr, 0);
        en = 8'hFF;
        tick();
        chk("mask_entry", intr_o, 1);
        chk("mask_act", act_o, 2);
        run_isr(2, 3);

        // Ignored mret in IDLE/STACKING, restore_done in SERVICE
        irq = 8'h00;
        tick();
        mret = 1'b1; tick(); mret = 1'b0;
        chk("ign_mret_idle", insvc_o, 0);
        irq = 8'h40;
        wait_intr(10, k);
        busy = 1'b1; tick();
        mret = 1'b1; tick(); mret = 1'b0;
        chk("ign_mret_stack", ret_o, 0);
        tick(2);
        busy = 1'b0; tick();
        done = 1'b1; tick(); done = 1'b0;
        chk("ign_done_service", insvc_o, 1);
        chk("ign_done_stall", stall_o, 0);
        mret = 1'b1; tick(); mret = 1'b0;
        tick(2);
        done = 1'b1; tick(); done = 1'b0;

        // Reset during STACKING with IRQ 7 still pending
        irq = 8'h00;
        tick();
        irq = 8'h81;
        wait_intr(10, k);
        busy = 1'b1;
        tick(3);
        async_reset();
        busy = 1'b0;
        tick(10);
        chk("rst_pending_cleared", insvc_o, 0);
        irq = 8'h00;
        tick();

        // Pending collision on line 4: accepted and re-armed on the same edge
        gen = 1'b0;
        irq = 8'h10; tick();
        irq = 8'h00; tick();
        gen = 1'b1; irq = 8'h10;
        tick();
        chk("coll_first", intr_o, 1);
        chk("coll_first_act", act_o, 4);
        run_isr(2, 1);
        tick();
        chk("coll_second", intr_o, 1);
        chk("coll_second_act", act_o, 4);
        run_isr(2, 1);

        // Random phase against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) begin
                b = $urandom_range(7);
                irq[b] = ~irq[b];
            end
            en   = 8'($urandom | $urandom);
            gen  = ($urandom_range(9) != 0);
            mret = ($urandom_range(3) == 0);
            busy = $urandom_range(1) != 0;
            done = ($urandom_range(4) == 0);
            if ($urandom_range(599) == 0) async_reset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
